fifo_flow_fsm: RTL

Main control state machine for the 4-in/4-out FIFO switch datapath. It sequences the datapath through reset, threshold configuration, idle and active operation. It latches the almost-full and almost-empty thresholds shared by all FIFOs and gates the arbiter's pop/push activity with arb_enable. FIFO overflow/underflow flags are captured into a sticky error state that only reset clears.

---
 rtl/fifo_flow_fsm_if.sv | 53 +++++
 rtl/fifo_flow_fsm.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/fifo_flow_fsm_if.sv
// ---------------------------------------------------------------------------
// fifo_flow_fsm_if
// Groups the control/status signals of the FIFO switch main state machine.
//   master : the side that drives init, the threshold inputs and the FIFO
//            flags (datapath / configuration logic, or a testbench).
//   slave  : the fifo_flow_fsm controller itself.
// Signals:
//   init            level-sensitive request to enter/stay in INIT
//   umbral_hi_in    almost-full threshold to load
//   umbral_lo_in    almost-empty threshold to load
//   in_fifos_empty  empty flags of the 4 input FIFOs
//   out_fifos_empty empty flags of the 4 output FIFOs
//   fifo_errors     error pulses; [3:0] input FIFOs, [7:4] output FIFOs
//   state           current state code
//   umbral_hi/lo    latched thresholds
//   arb_enable      arbiter may pop/push
//   idle_out        high in IDLE
//   error_out       high in ERROR
//   error_src       sticky OR of fifo_errors seen since entering ERROR
//   cfg_invalid     last threshold check in INIT failed
// ---------------------------------------------------------------------------
interface fifo_flow_fsm_if #(
    parameter int THRESH_W = 3
);
    logic                init;
    logic [THRESH_W-1:0] umbral_hi_in;
    logic [THRESH_W-1:0] umbral_lo_in;
    logic [3:0]          in_fifos_empty;
    logic [3:0]          out_fifos_empty;
    logic [7:0]          fifo_errors;
    logic [2:0]          state;
    logic [THRESH_W-1:0] umbral_hi;
    logic [THRESH_W-1:0] umbral_lo;
    logic                arb_enable;
    logic                idle_out;
    logic                error_out;
    logic [7:0]          error_src;
    logic                cfg_invalid;

    modport master (
        output init, umbral_hi_in, umbral_lo_in,
               in_fifos_empty, out_fifos_empty, fifo_errors,
        input  state, umbral_hi, umbral_lo, arb_enable,
               idle_out, error_out, error_src, cfg_invalid
    );

    modport slave (
        input  init, umbral_hi_in, umbral_lo_in,
               in_fifos_empty, out_fifos_empty, fifo_errors,
        output state, umbral_hi, umbral_lo, arb_enable,
               idle_out, error_out, error_src, cfg_invalid
    );
endinterface

// File: rtl/fifo_flow_fsm.sv
// ---------------------------------------------------------------------------
// fifo_flow_fsm
// Main control FSM of the 4-in/4-out FIFO switch. Sequences the datapath
// through RESET -> INIT -> IDLE <-> ACTIVE, latches the shared almost-full /
// almost-empty thresholds while in INIT, gates the arbiter with arb_enable
// and traps any FIFO overflow/underflow into a sticky ERROR state that only
// reset leaves.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low reset
//   bus    fifo_flow_fsm_if.slave (see interface header for signal list)
// All outputs are registered and decoded from the next state (Moore).
// Optional feature: define THRESH_CHECK_EN to validate thresholds on the
// way out of INIT (lo < hi and hi <= FIFO_DEPTH-1); invalid values keep the
// FSM in INIT with cfg_invalid set. Without it cfg_invalid is always 0.
// ---------------------------------------------------------------------------
module fifo_flow_fsm #(
    parameter int THRESH_W   = 3,
    parameter int FIFO_DEPTH = 8
) (
    input logic              clk,
    input logic              reset,
    fifo_flow_fsm_if.slave   bus
);

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_INIT   = 3'd1,
        S_IDLE   = 3'd2,
        S_ACTIVE = 3'd3,
        S_ERROR  = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [THRESH_W-1:0] umbral_hi_q, umbral_hi_d;
    logic [THRESH_W-1:0] umbral_lo_q, umbral_lo_d;
    logic [7:0]          error_src_q, error_src_d;
    logic                cfg_invalid_q, cfg_invalid_d;
    logic                arb_enable_q, idle_out_q, error_out_q;
    logic                any_error;
    logic                thresh_ok;

    assign any_error = |bus.fifo_errors;

`ifdef THRESH_CHECK_EN
    localparam int unsigned HI_MAX = FIFO_DEPTH - 1;
    assign thresh_ok = (bus.umbral_lo_in < bus.umbral_hi_in) &&
                       (32'(bus.umbral_hi_in) <= HI_MAX);
`else
    assign thresh_ok = 1'b1;
`endif

    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d       = state_q;
        umbral_hi_d   = umbral_hi_q;
        umbral_lo_d   = umbral_lo_q;
        error_src_d   = error_src_q;
        cfg_invalid_d = cfg_invalid_q;

        case (state_q)
            S_RESET: state_d = S_INIT;  // fifo_errors deliberately ignored

            S_INIT: begin
                umbral_hi_d = bus.umbral_hi_in;
                umbral_lo_d = bus.umbral_lo_in;
                if (any_error) begin
                    state_d     = S_ERROR;
                    error_src_d = bus.fifo_errors;
                end else if (!bus.init) begin
                    if (thresh_ok) state_d       = S_IDLE;
                    else           cfg_invalid_d = 1'b1;
                end
            end

            S_IDLE: begin
                if (any_error) begin
                    state_d     = S_ERROR;
                    error_src_d = bus.fifo_errors;
                end else if (bus.init) begin
                    state_d = S_INIT;
                end else if (!(&bus.in_fifos_empty)) begin
                    state_d = S_ACTIVE;
                end
            end

            S_ACTIVE: begin
                if (any_error) begin
                    state_d     = S_ERROR;
                    error_src_d = bus.fifo_errors;
                end else if (bus.init) begin
                    state_d = S_INIT;
                end else if ((&bus.in_fifos_empty) && (&bus.out_fifos_empty)) begin
                    // Only return to IDLE once the output side has drained too.
                    state_d = S_IDLE;
                end
            end

            S_ERROR: error_src_d = error_src_q | bus.fifo_errors;

            default: state_d = S_RESET;  // illegal codes 5..7
        endcase

        // The flag only describes a pending INIT; it drops as soon as we leave.
        if (state_d != S_INIT) cfg_invalid_d = 1'b0;
`ifndef THRESH_CHECK_EN
        cfg_invalid_d = 1'b0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= S_RESET;
            umbral_hi_q   <= '0;
            umbral_lo_q   <= '0;
            error_src_q   <= '0;
            cfg_invalid_q <= 1'b0;
            arb_enable_q  <= 1'b0;
            idle_out_q    <= 1'b0;
            error_out_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            umbral_hi_q   <= umbral_hi_d;
            umbral_lo_q   <= umbral_lo_d;
            error_src_q   <= error_src_d;
            cfg_invalid_q <= cfg_invalid_d;
            arb_enable_q  <= (state_d == S_IDLE) || (state_d == S_ACTIVE);
            idle_out_q    <= (state_d == S_IDLE);
            error_out_q   <= (state_d == S_ERROR);
        end
    end

    assign bus.state       = state_q;
    assign bus.umbral_hi   = umbral_hi_q;
    assign bus.umbral_lo   = umbral_lo_q;
    assign bus.error_src   = error_src_q;
    assign bus.cfg_invalid = cfg_invalid_q;
    assign bus.arb_enable  = arb_enable_q;
    assign bus.idle_out    = idle_out_q;
    assign bus.error_out   = error_out_q;

endmodule
